// File: rtl/regfile_multiport_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_multiport_if
// Purpose  : Bus bundle for the multiport register bank. It carries one write
//            port, the packed read-address and read-data buses, and the
//            ready flag that the clear sequencer drives.
// Signals  : wr_en    1           write strobe
//            wr_addr  AW          write index
//            wr_data  XLEN        write data
//            rd_addr  NREAD*AW    read indices, port k = [k*AW +: AW]
//            rd_data  NREAD*XLEN  registered read data, port k = [k*XLEN +: XLEN]
//            ready    1           clear sequence finished
// Modports : master = CPU side, slave = register bank
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_multiport_if #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int NREAD = 2
);
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [XLEN-1:0]         wr_data;
    logic [NREAD*AW-1:0]     rd_addr;
    logic [NREAD*XLEN-1:0]   rd_data;
    logic                    ready;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data,
        input  ready
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : regfile_multiport
// Purpose  : RISC-V integer register bank with NREAD synchronous read ports
//            and one write port. After reset a clear sequencer walks every
//            register, writing zero (or INIT_VAL at INIT_IDX), then raises
//            ready and hands the write port to the CPU.
// Ports    : CLK     in   system clock, all state on posedge
//            RESETN  in   synchronous active-low reset
//            bus     slave modport of regfile_multiport_if
//                    (wr_en/wr_addr/wr_data, rd_addr, rd_data, ready)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_multiport #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              NREAD    = 2,
    parameter int              ZERO_REG = 1,
    parameter int              BYPASS   = 1,
    parameter int              INIT_IDX = 2,
    parameter logic [XLEN-1:0] INIT_VAL = 1
) (
    input  wire logic           CLK,
    input  wire logic           RESETN,
    regfile_multiport_if.slave  bus
);

    localparam int            AW         = $clog2(NREGS);
    localparam logic [AW-1:0] c_INIT_IDX = AW'(INIT_IDX);
    localparam logic [AW-1:0] c_LAST_IDX = AW'(NREGS - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [AW-1:0]           r_ptr;
    logic [AW-1:0]           w_ptr_nxt;

    logic [XLEN-1:0]         r_bank [NREGS];
    logic                    w_bank_we;
    logic [AW-1:0]           w_bank_addr;
    logic [XLEN-1:0]         w_bank_data;

    logic                    w_run_commit;
    logic [NREAD*XLEN-1:0]   w_rd_nxt;
    logic [NREAD*XLEN-1:0]   r_rd_data;

    // A CPU write commits only in RUN and never lands on x0 when it is hardwired.
    assign w_run_commit = (r_state == ST_RUN) && bus.wr_en &&
                          !((ZERO_REG != 0) && (bus.wr_addr == '0));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and bank write-port mux
    // The clear sequencer owns the bank write port until RUN; the pointer
    // stops at the last index instead of wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_bank_we   = 1'b0;
        w_bank_addr = r_ptr;
        w_bank_data = '0;
        case (r_state)
            ST_CLEAR: begin
                w_bank_we   = 1'b1;
                w_bank_addr = r_ptr;
                w_bank_data = (r_ptr == c_INIT_IDX) ? INIT_VAL : '0;
                if (r_ptr == c_LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_ptr_nxt = r_ptr + AW'(1);
                end
            end
            ST_RUN: begin
                w_bank_we   = w_run_commit;
                w_bank_addr = bus.wr_addr;
                w_bank_data = bus.wr_data;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register array: contents are not reset; the clear sequence does it.
    // Writes are blocked while RESETN is low so a mid-clear reset cannot
    // leave a stray write behind.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESETN && w_bank_we) begin
            r_bank[w_bank_addr] <= w_bank_data;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: priority is zero-register, then same-cycle forward,
    // then the pre-write array value. Outputs hold zero during CLEAR.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NREAD; k++) begin : g_rd_port
        logic [AW-1:0]   w_raddr;
        logic [XLEN-1:0] w_rdata;

        assign w_raddr = bus.rd_addr[k*AW +: AW];

        always_comb begin
            w_rdata = '0;
            if (r_state != ST_RUN) begin
                w_rdata = '0;
            end else if ((ZERO_REG != 0) && (w_raddr == '0)) begin
                w_rdata = '0;
            end else if ((BYPASS != 0) && w_run_commit && (bus.wr_addr == w_raddr)) begin
                w_rdata = bus.wr_data;
            end else begin
                w_rdata = r_bank[w_raddr];
            end
        end

        assign w_rd_nxt[k*XLEN +: XLEN] = w_rdata;
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_nxt;
        end
    end

    assign bus.rd_data = r_rd_data;
    assign bus.ready   = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_multiport
// Purpose  : Self-checking bench for regfile_multiport. Three instances:
//            A = defaults, B = ZERO_REG=0/BYPASS=0, C = 16 regs/3 read ports
//            with INIT_IDX=15, INIT_VAL=32'h80. Expected read data is queued
//            when a read is issued and compared once the DUT registers it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_multiport;

    logic clk;
    logic rstn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_multiport_if #(.XLEN(32), .AW(5), .NREAD(2)) ifa ();
    regfile_multiport_if #(.XLEN(32), .AW(5), .NREAD(2)) ifb ();
    regfile_multiport_if #(.XLEN(32), .AW(4), .NREAD(3)) ifc ();

    regfile_multiport #(
        .XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1),
        .INIT_IDX(2), .INIT_VAL(32'd1)
    ) dut_a (.CLK(clk), .RESETN(rstn), .bus(ifa));

    regfile_multiport #(
        .XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(0), .BYPASS(0),
        .INIT_IDX(2), .INIT_VAL(32'd1)
    ) dut_b (.CLK(clk), .RESETN(rstn), .bus(ifb));

    regfile_multiport #(
        .XLEN(32), .NREGS(16), .NREAD(3), .ZERO_REG(1), .BYPASS(1),
        .INIT_IDX(15), .INIT_VAL(32'h80)
    ) dut_c (.CLK(clk), .RESETN(rstn), .bus(ifc));

    typedef struct {
        int           dut;
        int           port;
        logic [31:0]  exp;
        logic [127:0] tag;
    } sb_t;

    sb_t sb_q[$];
    int  tests_run    = 0;
    int  tests_failed = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int p, input logic [31:0] exp, input logic [127:0] tag);
        sb_t e;
        e.dut  = d;
        e.port = p;
        e.exp  = exp;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] get_rd(input int d, input int p);
        case (d)
            0:       return ifa.rd_data[p*32 +: 32];
            1:       return ifb.rd_data[p*32 +: 32];
            default: return ifc.rd_data[p*32 +: 32];
        endcase
    endfunction

    task automatic idle_all();
        ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.rd_addr = '0;
        ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.rd_addr = '0;
        ifc.wr_en = 1'b0; ifc.wr_addr = '0; ifc.wr_data = '0; ifc.rd_addr = '0;
    endtask

    // Reset held for two edges: not ready, all read data zero.
    task automatic test_reset();
        sb_t e;
        logic [31:0] got;
        idle_all();
        rstn = 1'b0;
        tick();
        for (int p = 0; p < 2; p++) begin
            push(0, p, 32'h0, "reset_rd");
            push(1, p, 32'h0, "reset_rd");
        end
        for (int p = 0; p < 3; p++) push(2, p, 32'h0, "reset_rd");
        tick();
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            got = get_rd(e.dut, e.port);
            tests_run++;
            if (got !== e.exp) begin
                tests_failed++;
                $display("FAIL %0s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
            end
        end
        tests_run++;
        if ({ifa.ready, ifb.ready, ifc.ready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b expected 000", {ifa.ready, ifb.ready, ifc.ready});
        end
    endtask

    // ready must rise on exactly the NREGS-th edge after release.
    task automatic test_clear_sequence();
        logic [2:0] exp_rdy;
        rstn = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            tick();
            exp_rdy = {(i >= 16), (i >= 32), (i >= 32)};
            tests_run++;
            if ({ifc.ready, ifb.ready, ifa.ready} !== exp_rdy) begin
                tests_failed++;
                $display("FAIL clear_ready edge %0d: got c/b/a=%b expected %b",
                         i, {ifc.ready, ifb.ready, ifa.ready}, exp_rdy);
            end
        end
    endtask

    // After clear: x2 = 1, everything else 0, on both 32-entry banks.
    task automatic test_read_all();
        sb_t e;
        logic [31:0] got;
        for (int r = 0; r < 32; r += 2) begin
            ifa.rd_addr = {5'(r + 1), 5'(r)};
            ifb.rd_addr = {5'(r + 1), 5'(r)};
            push(0, 0, (r == 2) ? 32'd1 : 32'd0, "read_all");
            push(0, 1, 32'd0, "read_all");
            push(1, 0, (r == 2) ? 32'd1 : 32'd0, "read_all");
            push(1, 1, 32'd0, "read_all");
            tick();
            while (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                got = get_rd(e.dut, e.port);
                tests_run++;
                if (got !== e.exp) begin
                    tests_failed++;
                    $display("FAIL %0s x%0d dut%0d port%0d: got %h expected %h",
                             e.tag, r + e.port, e.dut, e.port, got, e.exp);
                end
            end
        end
    endtask

    task automatic test_write_read();
        sb_t e;
        logic [31:0] got;
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd5; ifa.wr_data = 32'hDEADBEEF;
        ifa.rd_addr = '0;
        tick();
        ifa.wr_en = 1'b0;
        ifa.rd_addr = {5'd2, 5'd5};
        push(0, 0, 32'hDEADBEEF, "write_read_x5");
        push(0, 1, 32'd1, "write_read_x2");
        tick();
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            got = get_rd(e.dut, e.port);
            tests_run++;
            if (got !== e.exp) begin
                tests_failed++;
                $display("FAIL %0s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
            end
        end
    endtask

    // x0 hardwired on A, ordinary register on B.
    task automatic test_zero_reg();
        sb_t e;
        logic [31:0] got;
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd0; ifa.wr_data = 32'h1234; ifa.rd_addr = {5'd3, 5'd3};
        ifb.wr_en = 1'b1; ifb.wr_addr = 5'd0; ifb.wr_data = 32'h1234; ifb.rd_addr = {5'd3, 5'd3};
        tick();
        ifa.wr_en = 1'b0; ifa.rd_addr = '0;
        ifb.wr_en = 1'b0; ifb.rd_addr = '0;
        push(0, 0, 32'h0, "zero_reg_x0");
        push(0, 1, 32'h0, "zero_reg_x0");
        push(1, 0, 32'h1234, "plain_x0");
        push(1, 1, 32'h1234, "plain_x0");
        tick();
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            got = get_rd(e.dut, e.port);
            tests_run++;
            if (got !== e.exp) begin
                tests_failed++;
                $display("FAIL %0s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
            end
        end
    endtask

    // Same-cycle write/read of x7: forwarded on A, old value on B.
    task automatic test_bypass();
        sb_t e;
        logic [31:0] got;
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd7; ifa.wr_data = 32'hA5A5A5A5; ifa.rd_addr = {5'd7, 5'd7};
        ifb.wr_en = 1'b1; ifb.wr_addr = 5'd7; ifb.wr_data = 32'hA5A5A5A5; ifb.rd_addr = {5'd7, 5'd7};
        push(0, 0, 32'hA5A5A5A5, "bypass_same");
        push(0, 1, 32'hA5A5A5A5, "bypass_same");
        push(1, 0, 32'h0, "nobypass_same");
        push(1, 1, 32'h0, "nobypass_same");
        tick();
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            got = get_rd(e.dut, e.port);
            tests_run++;
            if (got !== e.exp) begin
                tests_failed++;
                $display("FAIL %0s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
            end
        end
        ifa.wr_en = 1'b0;
        ifb.wr_en = 1'b0;
        push(0, 0, 32'hA5A5A5A5, "bypass_next");
        push(1, 0, 32'hA5A5A5A5, "nobypass_next");
        tick();
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            got = get_rd(e.dut, e.port);
            tests_run++;
            if (got !== e.exp) begin
                tests_failed++;
                $display("FAIL %0s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
            end
        end
        ifa.rd_addr = '0;
        ifb.rd_addr = '0;
    endtask

    // Small bank: preset at the last index, several ports on one register.
    task automatic test_small_config();
        sb_t e;
        logic [31:0] got;
        ifc.rd_addr = {4'd15, 4'd1, 4'd15};
        push(2, 0, 32'h80, "small_x15");
        push(2, 1, 32'h0, "small_x1");
        push(2, 2, 32'h80, "small_x15");
        tick();
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            got = get_rd(e.dut, e.port);
            tests_run++;
            if (got !== e.exp) begin
                tests_failed++;
                $display("FAIL %0s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
            end
        end
        ifc.rd_addr = '0;
    endtask

    // Reset at clear cycle 10 with a pending write; clear restarts from 0
    // and ignores the write, leaving x3 zero.
    task automatic test_reset_mid_clear();
        sb_t e;
        logic [31:0] got;
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd3; ifa.wr_data = 32'hFF;
        tick();
        ifa.wr_en = 1'b0; ifa.rd_addr = {5'd0, 5'd3};
        push(0, 0, 32'hFF, "premid_x3");
        tick();
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            got = get_rd(e.dut, e.port);
            tests_run++;
            if (got !== e.exp) begin
                tests_failed++;
                $display("FAIL %0s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
            end
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        ifa.wr_en = 1'b1; ifa.wr_addr = 5'd3; ifa.wr_data = 32'hFF; ifa.rd_addr = {5'd0, 5'd3};
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            push(0, 0, 32'h0, "midclear_rd");
            tick();
            while (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                got = get_rd(e.dut, e.port);
                tests_run++;
                if (got !== e.exp) begin
                    tests_failed++;
                    $display("FAIL %0s edge %0d port%0d: got %h expected %h", e.tag, i, e.port, got, e.exp);
                end
            end
            tests_run++;
            if (ifa.ready !== (i >= 32)) begin
                tests_failed++;
                $display("FAIL midclear_ready edge %0d: got %b expected %b", i, ifa.ready, (i >= 32));
            end
        end
        ifa.wr_en = 1'b0;
        push(0, 0, 32'h0, "postclear_x3");
        tick();
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            got = get_rd(e.dut, e.port);
            tests_run++;
            if (got !== e.exp) begin
                tests_failed++;
                $display("FAIL %0s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        idle_all();
        test_reset();
        test_clear_sequence();
        test_read_all();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_small_config();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
